// File: rtl/led_blink_arbiter_if.sv
// Request/status bundle between the status sources (master) and the LED arbiter (slave).
interface led_blink_arbiter_if #(
    parameter int N_REQ = 4
);
    logic [N_REQ-1:0]   req;
    logic [3*N_REQ-1:0] blink_cnt;
    logic [N_REQ-1:0]   grant;
    logic               busy;
    logic               done;
    logic               led;

    modport master (output req, blink_cnt, input grant, busy, done, led);
    modport slave  (input req, blink_cnt, output grant, busy, done, led);
endinterface

// File: rtl/led_blink_arbiter.sv
// led_blink_arbiter: round-robin owner of the single status LED, playing 1..8 pulse blink codes.
// Defining LED_HEARTBEAT_EN adds a 1-in-8-tick idle heartbeat flash on the LED.
module led_blink_arbiter #(
    parameter int N_REQ     = 4,
    parameter int TICK_DIV  = 5_000_000,
    parameter int GAP_TICKS = 2
) (
    input  logic               clk,
    input  logic               rst,
    led_blink_arbiter_if.slave bus
);
    localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CW = $clog2(TICK_DIV);
    localparam int GW = $clog2(GAP_TICKS + 1);

    typedef enum logic [1:0] {S_IDLE, S_ON, S_OFF, S_GAP} state_t;

    state_t           state_q, state_n;
    logic [CW-1:0]    presc_q, presc_n;
    logic [PW-1:0]    ptr_q, ptr_n, pick, cand;
    logic [3:0]       rem_q, rem_n;
    logic [GW-1:0]    gap_q, gap_n;
    logic [N_REQ-1:0] grant_q, grant_n;
    logic             done_q, done_n, led_q, led_n;
    logic             found, tick;
    logic [2:0]       sel_cnt;
`ifdef LED_HEARTBEAT_EN
    logic [2:0]       hb_q, hb_n;
`endif

    assign tick = (presc_q == CW'(TICK_DIV - 1));

    // Round-robin search: first set request after the last granted index, wrapping.
    always_comb begin
        found   = 1'b0;
        pick    = ptr_q;
        cand    = '0;
        sel_cnt = '0;
        for (int i = 1; i <= N_REQ; i++) begin
            cand = PW'((int'(ptr_q) + i) % N_REQ);
            if (!found && bus.req[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end
        for (int i = 0; i < N_REQ; i++) begin
            if (pick == PW'(i)) sel_cnt = bus.blink_cnt[3*i +: 3];
        end
    end

    // NOTE: every next-state value gets a default first, so no path leaves a latch behind.
    always_comb begin
        state_n = state_q;
        presc_n = tick ? '0 : presc_q + CW'(1);
        ptr_n   = ptr_q;
        rem_n   = rem_q;
        gap_n   = gap_q;
        grant_n = grant_q;
        done_n  = 1'b0;
        unique case (state_q)
            S_IDLE: if (found) begin
                ptr_n   = pick;
                rem_n   = (sel_cnt == 3'd0) ? 4'd8 : {1'b0, sel_cnt};
                grant_n = {{(N_REQ-1){1'b0}}, 1'b1} << pick;
                presc_n = '0;
                state_n = S_ON;
            end
            S_ON:  if (tick) state_n = S_OFF;
            S_OFF: if (tick) begin
                rem_n = rem_q - 4'd1;
                if (rem_q == 4'd1) begin
                    gap_n   = GW'(GAP_TICKS);
                    state_n = S_GAP;
                end else begin
                    state_n = S_ON;
                end
            end
            S_GAP: if (tick) begin
                if (gap_q == GW'(1)) begin
                    grant_n = '0;
                    done_n  = 1'b1;
                    state_n = S_IDLE;
                end else begin
                    gap_n = gap_q - GW'(1);
                end
            end
            default: state_n = S_IDLE;
        endcase

        led_n = (state_n == S_ON);
`ifdef LED_HEARTBEAT_EN
        // Heartbeat restarts on every entry to IDLE so the flash follows each done pulse.
        hb_n = hb_q;
        if (state_n == S_IDLE) begin
            if (state_q != S_IDLE) hb_n = '0;
            else if (tick)         hb_n = hb_q + 3'd1;
            led_n = (hb_n == 3'd0);
        end
`endif
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            presc_q <= '0;
            ptr_q   <= PW'(N_REQ - 1);
            rem_q   <= '0;
            gap_q   <= '0;
            grant_q <= '0;
            done_q  <= 1'b0;
            led_q   <= 1'b0;
`ifdef LED_HEARTBEAT_EN
            hb_q    <= '0;
`endif
        end else begin
            state_q <= state_n;
            presc_q <= presc_n;
            ptr_q   <= ptr_n;
            rem_q   <= rem_n;
            gap_q   <= gap_n;
            grant_q <= grant_n;
            done_q  <= done_n;
            led_q   <= led_n;
`ifdef LED_HEARTBEAT_EN
            hb_q    <= hb_n;
`endif
        end
    end

    assign bus.grant = grant_q;
    assign bus.busy  = |grant_q;
    assign bus.done  = done_q;
    assign bus.led   = led_q;
endmodule
